// File: rtl/spi_ram_pkg.sv
// Shared constants and types for the SPI serial-RAM master.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Bit counter width; covers the longest single phase (32 data bits).
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_ram_phase.sv
// SPI clock generator: CLK_DIV clk cycles low, then CLK_DIV high, per bit.
// rise/fall flag the clk edge on which spi_clk toggles 0->1 / 1->0.
module spi_ram_phase #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic spi_clk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt;
  logic             half_end;

  assign half_end = (cnt == DIV_W'(CLK_DIV - 1));
  assign rise     = run && !spi_clk && half_end;
  assign fall     = run &&  spi_clk && half_end;

  // Half-period counter; spi_clk is a register so it cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      spi_clk <= 1'b0;
    end else if (half_end) begin
      cnt     <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// 23LC-style SPI RAM master: one word read/write per request, sent as
// command byte, address (MSB first) and little-endian data burst.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              spi_select,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N = 8 + ADDR_W + DATA_W;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             write_q;
  logic             rdy;
  logic [N-1:0]     sr;
  logic             run;
  logic             rise;
  logic             fall;
  logic             accept;

  // Byte-reverse a word: lowest-addressed byte travels first on the wire.
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

  assign req_ready = rdy;
  assign busy      = !rdy;
  assign accept    = (state == ST_IDLE) && req_valid && rdy;
  assign run       = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);

  spi_ram_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .spi_clk (spi_clk),
    .rise    (rise),
    .fall    (fall)
  );

  // Frame shift register: loaded on accept, shifts MISO in at each rising SPI edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      sr <= {(req_write ? CMD_WRITE : CMD_READ), req_addr,
             (req_write ? byte_swap(req_wdata) : {DATA_W{1'b0}})};
    end else if (rise) begin
      sr <= {sr[N-2:0], spi_miso};
    end
  end

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      write_q    <= 1'b0;
      rdy        <= 1'b0;
      spi_select <= 1'b1;
      spi_mosi   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          rdy <= 1'b1;
          if (accept) begin
            state      <= ST_CMD;
            bit_cnt    <= CNT_W'(7);
            write_q    <= req_write;
            rdy        <= 1'b0;
            spi_select <= 1'b0;
            spi_mosi   <= req_write ? CMD_WRITE[7] : CMD_READ[7];
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          if (fall) begin
            if (bit_cnt != '0) begin
              bit_cnt  <= bit_cnt - 1'b1;
              spi_mosi <= sr[N-1];
            end else if (state == ST_CMD) begin
              state    <= ST_ADDR;
              bit_cnt  <= CNT_W'(ADDR_W - 1);
              spi_mosi <= sr[N-1];
            end else if (state == ST_ADDR) begin
              state    <= ST_DATA;
              bit_cnt  <= CNT_W'(DATA_W - 1);
              spi_mosi <= sr[N-1];
            end else begin
              state      <= ST_DONE;
              spi_select <= 1'b1;
              spi_mosi   <= 1'b0;
              rsp_valid  <= 1'b1;
              if (!write_q) begin
                rsp_rdata <= byte_swap(sr[DATA_W-1:0]);
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          rdy   <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a default instance (A) and an
// ADDR_W=24 / DATA_W=8 / CLK_DIV=3 instance (B), each with a small SPI slave.
module tb_spi_ram_ctrl;

  localparam int HIST = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Instance A (defaults)
  logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
  logic [15:0] a_req_addr = '0, a_req_wdata = '0, a_rsp_rdata;
  logic        a_rsp_valid, a_busy, a_sel, a_sclk, a_mosi, a_miso;
  // Instance B (24-bit address, byte data, slow clock)
  logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
  logic [23:0] b_req_addr = '0;
  logic [7:0]  b_req_wdata = '0, b_rsp_rdata;
  logic        b_rsp_valid, b_busy, b_sel, b_sclk, b_mosi, b_miso;

  spi_ram_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .busy(a_busy),
    .spi_select(a_sel), .spi_clk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  spi_ram_ctrl #(.ADDR_W(24), .DATA_W(8), .CLK_DIV(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .spi_select(b_sel), .spi_clk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  // Slave state: MOSI capture, rise count, bit vector served on MISO
  logic [39:0] a_cap = '0, b_cap = '0, a_mvec = '0, b_mvec = '0;
  int          a_rises = 0, b_rises = 0;
  logic        a_sclk_q = 1'b0, b_sclk_q = 1'b0;
  int          a_acc[$];
  int          b_acc[$];
  logic        a_rsp_h [HIST];
  logic        a_sel_h [HIST];
  logic        b_rsp_h [HIST];
  int          b_hi_run = 0, b_hi_min = 1000, b_hi_max = 0;
  int          a_t_rsp = 0, b_t_rsp = 0;

  function automatic logic mbit(input logic [39:0] v, input int k);
    if (k < 0 || k > 39) return 1'b0;
    return v[39-k];
  endfunction

  assign a_miso = mbit(a_mvec, a_rises);
  assign b_miso = mbit(b_mvec, b_rises);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_req_valid && a_req_ready) a_acc.push_back(cyc);
    if (b_req_valid && b_req_ready) b_acc.push_back(cyc);
    a_sclk_q <= a_sclk;
    b_sclk_q <= b_sclk;
    if (a_sel) a_rises <= 0;
    else if (a_sclk && !a_sclk_q) begin
      a_rises <= a_rises + 1;
      a_cap   <= {a_cap[38:0], a_mosi};
    end
    if (b_sel) b_rises <= 0;
    else if (b_sclk && !b_sclk_q) begin
      b_rises <= b_rises + 1;
      b_cap   <= {b_cap[38:0], b_mosi};
    end
  end

  always @(negedge clk) begin
    if (cyc < HIST) begin
      a_rsp_h[cyc] <= a_rsp_valid;
      a_sel_h[cyc] <= a_sel;
      b_rsp_h[cyc] <= b_rsp_valid;
    end
    if (b_sclk) b_hi_run <= b_hi_run + 1;
    else if (b_hi_run != 0) begin
      b_hi_min <= (b_hi_run < b_hi_min) ? b_hi_run : b_hi_min;
      b_hi_max <= (b_hi_run > b_hi_max) ? b_hi_run : b_hi_max;
      b_hi_run <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_rsp(input bit inst_b, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i >= 0 && i < HIST) begin
        if (inst_b ? (b_rsp_h[i] === 1'b1) : (a_rsp_h[i] === 1'b1)) c++;
      end
    end
    return c;
  endfunction

  task automatic a_start(input logic w, input logic [15:0] ad, input logic [15:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    a_req_write = w; a_req_addr = ad; a_req_wdata = wd; a_req_valid = 1'b1;
    while (!a_req_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("a_accept_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_addr = 16'hFFFF; a_req_wdata = 16'h0000;
  endtask

  task automatic a_finish(input bit noise);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_rsp_valid && n < 1000) begin
      if (noise) begin
        a_req_valid = ~a_req_valid;
        a_req_write = ~a_req_write;
        a_req_addr  = 16'($urandom);
        a_req_wdata = 16'($urandom);
      end
      @(negedge clk); n++;
    end
    a_req_valid = 1'b0;
    if (n >= 1000) check("a_rsp_timeout", 64'(n), 64'(0));
    a_t_rsp = cyc;
  endtask

  task automatic b_read(input logic [23:0] ad);
    int n;
    n = 0;
    @(negedge clk);
    b_req_write = 1'b0; b_req_addr = ad; b_req_valid = 1'b1;
    while (!b_req_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_req_addr = 24'hFFFFFF;
    n = 0;
    @(negedge clk);
    while (!b_rsp_valid && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("b_rsp_timeout", 64'(n), 64'(0));
    b_t_rsp = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tr, n0, n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(a_req_ready), 64'(0));
    check("rst_busy",   64'(a_busy),      64'(1));
    check("rst_sel",    64'(a_sel),       64'(1));
    check("rst_sclk",   64'(a_sclk),      64'(0));
    check("rst_mosi",   64'(a_mosi),      64'(0));
    check("rst_rspv",   64'(a_rsp_valid), 64'(0));
    check("rst_rdata",  64'(a_rsp_rdata), 64'(0));
    check("rst_b_sel",  64'(b_sel),       64'(1));
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready",  64'(a_req_ready), 64'(1));

    // Write 0x1234 <- 0xBEEF with request noise during the transaction
    a_start(1'b1, 16'h1234, 16'hBEEF);
    t0 = a_acc[$];
    a_finish(1'b1);
    check("wr_lat",    64'(a_t_rsp - t0), 64'(81));
    check("wr_frame",  64'(a_cap),        64'h02_1234_EFBE);
    check("wr_rises",  64'(a_rises),      64'(40));
    check("wr_rdata",  64'(a_rsp_rdata),  64'(0));
    repeat (3) @(negedge clk);
    check("wr_pulses", 64'(cnt_rsp(1'b0, t0, t0 + 84)), 64'(1));

    // Read 0x0040: RAM holds 0x5A @0x40, 0xC3 @0x41
    a_mvec = {24'hFFFFFF, 8'h5A, 8'hC3};
    a_start(1'b0, 16'h0040, 16'h0000);
    t0 = a_acc[$];
    a_finish(1'b1);
    check("rd_lat",    64'(a_t_rsp - t0), 64'(81));
    check("rd_rdata",  64'(a_rsp_rdata),  64'hC35A);
    check("rd_frame",  64'(a_cap),        64'h03_0040_0000);
    check("rd_rises",  64'(a_rises),      64'(40));

    // A later write leaves the last read word in place
    a_start(1'b1, 16'h00FF, 16'h0102);
    a_finish(1'b0);
    check("wr2_frame", 64'(a_cap),        64'h02_00FF_0201);
    check("wr2_rdata", 64'(a_rsp_rdata),  64'hC35A);

    // Back-to-back: write then read held on req_valid
    a_mvec = {24'h000000, 8'h88, 8'h77};
    @(negedge clk);
    n0 = a_acc.size();
    a_req_write = 1'b1; a_req_addr = 16'h2000; a_req_wdata = 16'h7788; a_req_valid = 1'b1;
    n = 0;
    while (a_acc.size() < n0 + 1 && n < 300) begin @(posedge clk); #1; n++; end
    a_req_write = 1'b0;
    n = 0;
    while (a_acc.size() < n0 + 2 && n < 300) begin @(posedge clk); #1; n++; end
    a_req_valid = 1'b0;
    check("q_accepts", 64'(a_acc.size() - n0), 64'(2));
    if (a_acc.size() >= n0 + 2) begin
      t0 = a_acc[n0];
      t1 = a_acc[n0 + 1];
      a_finish(1'b0);
      repeat (2) @(negedge clk);
      check("q_gap",     64'(t1 - t0),            64'(82));
      check("q_rsp1",    64'(a_rsp_h[t0 + 81]),   64'(1));
      check("q_rsp2",    64'(a_rsp_h[t1 + 81]),   64'(1));
      check("q_sel80",   64'(a_sel_h[t0 + 80]),   64'(0));
      check("q_sel81",   64'(a_sel_h[t0 + 81]),   64'(1));
      check("q_sel82",   64'(a_sel_h[t0 + 82]),   64'(1));
      check("q_sel83",   64'(a_sel_h[t0 + 83]),   64'(0));
      check("q_rdata",   64'(a_rsp_rdata),        64'h7788);
    end

    // Abort a read with reset after the 10th SPI rise, then redo it
    a_mvec = {24'hFFFFFF, 8'hA5, 8'h3C};
    a_start(1'b0, 16'h0300, 16'h0000);
    tr = a_acc[$];
    n = 0;
    while (a_rises < 10 && n < 200) begin @(negedge clk); n++; end
    check("ab_rises", 64'(a_rises), 64'(10));
    rst_n = 1'b0;
    #1;
    check("ab_sel",   64'(a_sel),       64'(1));
    check("ab_sclk",  64'(a_sclk),      64'(0));
    check("ab_mosi",  64'(a_mosi),      64'(0));
    check("ab_ready", 64'(a_req_ready), 64'(0));
    check("ab_rdata", 64'(a_rsp_rdata), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ab_rel_ready", 64'(a_req_ready), 64'(1));
    a_start(1'b0, 16'h0300, 16'h0000);
    t0 = a_acc[$];
    a_finish(1'b0);
    check("ab_no_rsp", 64'(cnt_rsp(1'b0, tr, t0)), 64'(0));
    check("ab_lat",    64'(a_t_rsp - t0),          64'(81));
    check("ab_rdata",  64'(a_rsp_rdata),           64'h3CA5);

    // Instance B: 24-bit address, 8-bit data, CLK_DIV=3
    b_mvec = {32'hFFFFFFFF, 8'h96};
    b_read(24'h01ABCD);
    t0 = b_acc[$];
    check("b_lat",    64'(b_t_rsp - t0), 64'(241));
    check("b_rdata",  64'(b_rsp_rdata),  64'h96);
    check("b_frame",  64'(b_cap),        64'h03_01ABCD_00);
    check("b_rises",  64'(b_rises),      64'(40));
    repeat (3) @(negedge clk);
    check("b_hi_min", 64'(b_hi_min),     64'(3));
    check("b_hi_max", 64'(b_hi_max),     64'(3));
    check("b_pulses", 64'(cnt_rsp(1'b1, t0, t0 + 244)), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Parametrised SPI serial-RAM master that turns single-word read/write requests from the CPU core into complete 23LC-style SPI transactions (command, address, data) on the external RAM pins. Successor to the fixed 8-bit/16-bit-address memory path: address width, word width and SPI clock rate are generics. Multi-byte words are transferred as one burst. A valid/ready request port and a one-cycle response strobe connect it to the core.

## Interface
Parameters:
- ADDR_W, 16, address bits sent on the bus; multiple of 8, range 8..24
- DATA_W, 16, word bits per transaction; multiple of 8, range 8..32
- CLK_DIV, 1, clk cycles per SPI half-period; >= 1

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle and accepting
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address of first byte
- req_wdata  in  DATA_W  write word
- rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes)
- rsp_rdata  out  DATA_W  last read word
- busy  out  1  transaction in progress (= !req_ready)
- spi_select  out  1  chip select, active low
- spi_clk  out  1  SPI clock, mode 0 (idle low)
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

## Operation
- States: IDLE -> CMD (8 bits) -> ADDR (ADDR_W bits) -> DATA (DATA_W bits) -> DONE -> IDLE.
- Accept on req_valid && req_ready; req_write/addr/wdata latched that cycle; request inputs ignored in every other state.
- Command byte: 8'h03 read, 8'h02 write. Address sent MSB first.
- Data bytes little-endian: byte at addr = word[7:0], addr+1 = word[15:8], etc. Each byte MSB first.
- Write: wdata shifted out in DATA; MOSI driven 0 during DATA of a read.
- Read: MISO shifted in during DATA; rsp_rdata updated only at end of a read. Writes leave rsp_rdata unchanged.
- N = 8 + ADDR_W + DATA_W bits per transaction.
- Reset (any state, async): spi_select=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, state IDLE. req_ready=0 while rst_n low, 1 from first clk after release. Aborted transaction produces no rsp_valid.

## Timing
- T0 = accept cycle. T0+1: spi_select low, spi_clk low, MOSI = cmd bit 7.
- Each bit = 2*CLK_DIV cycles: CLK_DIV low (MOSI changes at start of low phase), then CLK_DIV high.
- MISO sampled on the clk edge where spi_clk goes 0->1.
- After last bit's high phase: DONE cycle at T0+1+2*CLK_DIV*N with spi_clk=0, spi_select=1, rsp_valid=1 (rsp_rdata valid same cycle).
- IDLE at T0+2+2*CLK_DIV*N, req_ready=1; earliest next accept same cycle, so spi_select is high for >= 2 cycles between transactions.
- Defaults (N=40, CLK_DIV=1): rsp_valid at T0+81, next accept T0+82.
- spi_clk never glitches; exactly N rising edges per transaction.

## Structure
- Package spi_ram_pkg: CMD_READ = 8'h03, CMD_WRITE = 8'h02, state enum.
- One sub-module natural: spi_ram_phase, a CLK_DIV counter emitting rise/fall ticks and driving spi_clk; the top holds the FSM, bit counter and a single shift register of width 8+ADDR_W+DATA_W.

## Test plan
- Defaults, write addr 16'h1234 data 16'hBEEF -> MOSI bytes 02,12,34,EF,BE; 40 spi_clk rises; rsp_valid only at T0+81; rsp_rdata unchanged.
- Defaults, read 16'h0040 with RAM model bytes 0x5A @0x40, 0xC3 @0x41 -> rsp_rdata = 16'hC35A at T0+81; MOSI 0 through DATA.
- ADDR_W=24, DATA_W=8, CLK_DIV=3, read 24'h01ABCD -> MOSI 03,01,AB,CD; each spi_clk high exactly 3 cycles; rsp_valid at T0+241.
- req_valid held high with two queued requests -> second accepted at T0+82; spi_select high on cycles T0+81..T0+82; both rsp_valid pulses present.
- rst_n low after 10th spi_clk rise -> spi_select 1 and spi_clk 0 immediately, no rsp_valid; after release a fresh read completes with correct data.
- req_valid toggling with changed addr/wdata mid-transaction -> no effect on bus bits or result.
